// File: rtl/vram_arb_pkg.sv
// Shared types and default sizing for the VRAM CPU/video arbiter.
package vram_arb_pkg;

   localparam int ARB_AW          = 16;
   localparam int ARB_DW          = 32;
   localparam int ARB_VID_MAX_RUN = 4;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_CPU  = 2'd1,
      SRC_VID  = 2'd2
   } arb_src_t;

endpackage

// File: rtl/vram_cpu_arbiter_if.sv
// Bus bundle for the VRAM arbiter: CPU port, video fetch port and RAM macro port.
interface vram_cpu_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 32
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_adr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt;
   logic          cpu_done;
   logic [DW-1:0] cpu_rdata;

   logic          vid_req;
   logic [AW-1:0] vid_adr;
   logic          vid_gnt;
   logic          vid_rvalid;
   logic [DW-1:0] vid_rdata;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   // Requesters plus the RAM macro side.
   modport master (
      output cpu_req, cpu_we, cpu_adr, cpu_wdata,
      input  cpu_gnt, cpu_done, cpu_rdata,
      output vid_req, vid_adr,
      input  vid_gnt, vid_rvalid, vid_rdata,
      input  mem_en, mem_we, mem_adr, mem_wdata,
      output mem_rdata
   );

   // The arbiter itself.
   modport slave (
      input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
      output cpu_gnt, cpu_done, cpu_rdata,
      input  vid_req, vid_adr,
      output vid_gnt, vid_rvalid, vid_rdata,
      output mem_en, mem_we, mem_adr, mem_wdata,
      input  mem_rdata
   );
endinterface

// File: rtl/vram_cpu_arbiter_resp_pipe.sv
// Two-stage source-tag pipeline: turns issued accesses into cpu_done/vid_rvalid
// pulses and captures the returning RAM data.
module arb_resp_pipe
   import vram_arb_pkg::*;
#(
   parameter int DW = ARB_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  arb_src_t      issue_src,
   input  logic          issue_we,
   input  logic [DW-1:0] mem_rdata,
   output logic          cpu_done,
   output logic [DW-1:0] cpu_rdata,
   output logic          vid_rvalid,
   output logic [DW-1:0] vid_rdata
);

   arb_src_t      s1_src_q;
   logic          s1_we_q;
   arb_src_t      s2_src_q;
   logic          s2_we_q;
   logic          cpu_rd_hit;
   logic          vid_hit;
   logic [DW-1:0] cpu_rdata_d;
   logic [DW-1:0] cpu_rdata_q;
   logic [DW-1:0] vid_rdata_d;
   logic [DW-1:0] vid_rdata_q;

   // RAM data is only valid in the response cycle, so it is passed through then
   // and held in the register until the next response of the same source.
   always_comb begin
      cpu_rd_hit  = (s2_src_q == SRC_CPU) && !s2_we_q;
      vid_hit     = (s2_src_q == SRC_VID);
      cpu_rdata_d = cpu_rd_hit ? mem_rdata : cpu_rdata_q;
      vid_rdata_d = vid_hit ? mem_rdata : vid_rdata_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_src_q    <= SRC_NONE;
         s1_we_q     <= 1'b0;
         s2_src_q    <= SRC_NONE;
         s2_we_q     <= 1'b0;
         cpu_rdata_q <= {DW{1'b0}};
         vid_rdata_q <= {DW{1'b0}};
      end else begin
         s1_src_q    <= issue_src;
         s1_we_q     <= issue_we;
         s2_src_q    <= s1_src_q;
         s2_we_q     <= s1_we_q;
         cpu_rdata_q <= cpu_rdata_d;
         vid_rdata_q <= vid_rdata_d;
      end
   end

   assign cpu_done   = (s2_src_q == SRC_CPU);
   assign vid_rvalid = (s2_src_q == SRC_VID);
   assign cpu_rdata  = cpu_rdata_d;
   assign vid_rdata  = vid_rdata_d;

endmodule

// File: rtl/vram_cpu_arbiter.sv
// Single-port VRAM arbiter: video has priority, CPU is guaranteed a slot after
// VID_MAX_RUN video grants. Define VRAM_ARB_STATS_EN to add wait/read counters.
module vram_cpu_arbiter
   import vram_arb_pkg::*;
#(
   parameter int AW          = ARB_AW,
   parameter int DW          = ARB_DW,
   parameter int VID_MAX_RUN = ARB_VID_MAX_RUN
) (
   input  logic                clk,
   input  logic                reset,
   vram_cpu_arbiter_if.slave   bus
`ifdef VRAM_ARB_STATS_EN
   ,
   output logic [31:0]         stat_cpu_wait,
   output logic [31:0]         stat_vid_reads
`endif
);

   localparam int            RW      = $clog2(VID_MAX_RUN + 1);
   localparam logic [RW-1:0] RUN_MAX = RW'(VID_MAX_RUN);

   logic          cpu_eligible;
   logic          cpu_gnt;
   logic          vid_gnt;
   logic          cpu_done;
   arb_src_t      issue_src;
   logic          issue_we;

   logic [RW-1:0] run_cnt_d, run_cnt_q;
   logic          cpu_out_d, cpu_out_q;
   logic          mem_en_d, mem_en_q;
   logic          mem_we_d, mem_we_q;
   logic [AW-1:0] mem_adr_d, mem_adr_q;
   logic [DW-1:0] mem_wdata_d, mem_wdata_q;
   logic [DW-1:0] cpu_rdata_s;
   logic          vid_rvalid_s;
   logic [DW-1:0] vid_rdata_s;

   // Grant decision: starvation guard first, then video priority, then CPU.
   always_comb begin
      cpu_eligible = bus.cpu_req & ~cpu_out_q;
      cpu_gnt      = 1'b0;
      vid_gnt      = 1'b0;
      if (cpu_eligible && (run_cnt_q == RUN_MAX)) begin
         cpu_gnt = 1'b1;
      end else if (bus.vid_req) begin
         vid_gnt = 1'b1;
      end else if (cpu_eligible) begin
         cpu_gnt = 1'b1;
      end else begin
         cpu_gnt = 1'b0;
         vid_gnt = 1'b0;
      end
   end

   // Next state: run counter, single-outstanding CPU flag, and RAM issue regs.
   always_comb begin
      run_cnt_d   = run_cnt_q;
      cpu_out_d   = cpu_out_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_adr_d   = mem_adr_q;
      mem_wdata_d = mem_wdata_q;
      issue_src   = SRC_NONE;
      issue_we    = 1'b0;

      if (!bus.cpu_req || cpu_gnt) begin
         run_cnt_d = {RW{1'b0}};
      end else if (vid_gnt && (run_cnt_q != RUN_MAX)) begin
         run_cnt_d = run_cnt_q + RW'(1);
      end else begin
         run_cnt_d = run_cnt_q;
      end

      if (cpu_gnt) begin
         cpu_out_d = 1'b1;
      end else if (cpu_done) begin
         cpu_out_d = 1'b0;
      end else begin
         cpu_out_d = cpu_out_q;
      end

      if (cpu_gnt) begin
         mem_en_d    = 1'b1;
         mem_we_d    = bus.cpu_we;
         mem_adr_d   = bus.cpu_adr;
         mem_wdata_d = bus.cpu_wdata;
         issue_src   = SRC_CPU;
         issue_we    = bus.cpu_we;
      end else if (vid_gnt) begin
         mem_en_d    = 1'b1;
         mem_we_d    = 1'b0;
         mem_adr_d   = bus.vid_adr;
         issue_src   = SRC_VID;
      end else begin
         mem_en_d    = 1'b0;
         mem_we_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_cnt_q   <= {RW{1'b0}};
         cpu_out_q   <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_adr_q   <= {AW{1'b0}};
         mem_wdata_q <= {DW{1'b0}};
      end else begin
         run_cnt_q   <= run_cnt_d;
         cpu_out_q   <= cpu_out_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_adr_q   <= mem_adr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   arb_resp_pipe #(.DW(DW)) u_resp_pipe (
      .clk        (clk),
      .reset      (reset),
      .issue_src  (issue_src),
      .issue_we   (issue_we),
      .mem_rdata  (bus.mem_rdata),
      .cpu_done   (cpu_done),
      .cpu_rdata  (cpu_rdata_s),
      .vid_rvalid (vid_rvalid_s),
      .vid_rdata  (vid_rdata_s)
   );

   assign bus.cpu_gnt    = cpu_gnt;
   assign bus.vid_gnt    = vid_gnt;
   assign bus.cpu_done   = cpu_done;
   assign bus.cpu_rdata  = cpu_rdata_s;
   assign bus.vid_rvalid = vid_rvalid_s;
   assign bus.vid_rdata  = vid_rdata_s;
   assign bus.mem_en     = mem_en_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_adr    = mem_adr_q;
   assign bus.mem_wdata  = mem_wdata_q;

`ifdef VRAM_ARB_STATS_EN
   logic [31:0] stat_wait_d, stat_wait_q;
   logic [31:0] stat_vid_d, stat_vid_q;

   // Saturating event counters.
   always_comb begin
      if (cpu_eligible && !cpu_gnt && (stat_wait_q != 32'hFFFF_FFFF)) begin
         stat_wait_d = stat_wait_q + 32'd1;
      end else begin
         stat_wait_d = stat_wait_q;
      end
      if (vid_gnt && (stat_vid_q != 32'hFFFF_FFFF)) begin
         stat_vid_d = stat_vid_q + 32'd1;
      end else begin
         stat_vid_d = stat_vid_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_wait_q <= 32'd0;
         stat_vid_q  <= 32'd0;
      end else begin
         stat_wait_q <= stat_wait_d;
         stat_vid_q  <= stat_vid_d;
      end
   end

   assign stat_cpu_wait  = stat_wait_q;
   assign stat_vid_reads = stat_vid_q;
`endif

endmodule

// File: tb/tb_vram_cpu_arbiter.sv
// Randomized self-checking bench for vram_cpu_arbiter against a cycle-level
// transaction model (grant rules, issue-order memory image, 2-cycle responses).
module tb_vram_cpu_arbiter;
   import vram_arb_pkg::*;

   localparam int AW  = 16;
   localparam int DW  = 32;
   localparam int VMR = 4;

   logic clk = 1'b0;
   logic reset;
   logic ram_load;
   always #5 clk = ~clk;

   vram_cpu_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef VRAM_ARB_STATS_EN
   logic [31:0] stat_cpu_wait;
   logic [31:0] stat_vid_reads;
`endif

   vram_cpu_arbiter #(.AW(AW), .DW(DW), .VID_MAX_RUN(VMR)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef VRAM_ARB_STATS_EN
      ,
      .stat_cpu_wait  (stat_cpu_wait),
      .stat_vid_reads (stat_vid_reads)
`endif
   );

   function automatic logic [31:0] init_val(input int i);
      return (i == 16) ? 32'hDEAD_BEEF : ((32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000);
   endfunction

   // Environment RAM macro: registered read, data valid the cycle after mem_en.
   logic [31:0] ram [0:4095];
   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
      end else if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_adr[11:0]] <= bus.mem_wdata;
         else            bus.mem_rdata <= ram[bus.mem_adr[11:0]];
      end
   end

   typedef struct {
      int          due;
      bit          cpu;
      bit          rd;
      logic [31:0] data;
   } resp_t;

   resp_t       pend[$];
   logic [31:0] refmem [0:4095];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          m_run = 0;
   int          m_cpu_free_at = 0;
   bit          exp_mem_en, exp_mem_we;
   logic [15:0] exp_mem_adr;
   logic [31:0] exp_mem_wdata, exp_cpu_rdata, exp_vid_rdata;
   bit          dummy;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      m_run         = 0;
      m_cpu_free_at = 0;
      exp_mem_en    = 1'b0;
      exp_mem_we    = 1'b0;
      exp_mem_adr   = 16'h0;
      exp_mem_wdata = 32'h0;
      exp_cpu_rdata = 32'h0;
      exp_vid_rdata = 32'h0;
   endtask

   task automatic drive_idle();
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_adr   = 16'h0;
      bus.cpu_wdata = 32'h0;
      bus.vid_req   = 1'b0;
      bus.vid_adr   = 16'h0;
   endtask

   // Hold reset for 'cycles' edges, checking outputs stay cleared throughout.
   task automatic do_reset(input int cycles);
      reset = 1'b1;
      drive_idle();
      #1;
      for (int k = 0; k < cycles; k++) begin
         check_val("rst_mem_en", bus.mem_en, 0);
         check_val("rst_mem_we", bus.mem_we, 0);
         check_val("rst_mem_adr", bus.mem_adr, 0);
         check_val("rst_mem_wdata", bus.mem_wdata, 0);
         check_val("rst_cpu_done", bus.cpu_done, 0);
         check_val("rst_vid_rvalid", bus.vid_rvalid, 0);
         check_val("rst_cpu_rdata", bus.cpu_rdata, 0);
         check_val("rst_vid_rdata", bus.vid_rdata, 0);
         check_val("rst_gnt", {bus.cpu_gnt, bus.vid_gnt}, 0);
         @(posedge clk);
         #1;
         cyc++;
      end
      reset = 1'b0;
      model_reset();
   endtask

   // One clock cycle: apply inputs, compare against the model, advance the model.
   task automatic step(input bit creq, input bit cwe, input logic [15:0] cadr,
                       input logic [31:0] cwd, input bit vreq, input logic [15:0] vadr,
                       output bit cg);
      bit    elig, eg_cpu, eg_vid, ex_done, ex_vv;
      resp_t r;
      bus.cpu_req   = creq;
      bus.cpu_we    = cwe;
      bus.cpu_adr   = cadr;
      bus.cpu_wdata = cwd;
      bus.vid_req   = vreq;
      bus.vid_adr   = vadr;
      #1;
      elig   = creq && (cyc >= m_cpu_free_at);
      eg_cpu = 1'b0;
      eg_vid = 1'b0;
      if (elig && m_run == VMR) eg_cpu = 1'b1;
      else if (vreq)            eg_vid = 1'b1;
      else if (elig)            eg_cpu = 1'b1;

      check_val("cpu_gnt", bus.cpu_gnt, eg_cpu);
      check_val("vid_gnt", bus.vid_gnt, eg_vid);
      check_val("mem_en", bus.mem_en, exp_mem_en);
      check_val("mem_we", bus.mem_we, exp_mem_we);
      check_val("mem_adr", bus.mem_adr, exp_mem_adr);
      check_val("mem_wdata", bus.mem_wdata, exp_mem_wdata);

      ex_done = 1'b0;
      ex_vv   = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         r = pend.pop_front();
         if (r.cpu) begin
            ex_done = 1'b1;
            if (r.rd) exp_cpu_rdata = r.data;
         end else begin
            ex_vv = 1'b1;
            exp_vid_rdata = r.data;
         end
      end
      check_val("cpu_done", bus.cpu_done, ex_done);
      check_val("vid_rvalid", bus.vid_rvalid, ex_vv);
      check_val("cpu_rdata", bus.cpu_rdata, exp_cpu_rdata);
      check_val("vid_rdata", bus.vid_rdata, exp_vid_rdata);

      if (eg_cpu) begin
         m_cpu_free_at = cyc + 3;
         m_run         = 0;
         r.due = cyc + 2; r.cpu = 1'b1; r.rd = !cwe;
         if (cwe) begin
            refmem[cadr[11:0]] = cwd;
            r.data = 32'h0;
         end else begin
            r.data = refmem[cadr[11:0]];
         end
         pend.push_back(r);
         exp_mem_en = 1'b1; exp_mem_we = cwe; exp_mem_adr = cadr; exp_mem_wdata = cwd;
      end else if (eg_vid) begin
         r.due = cyc + 2; r.cpu = 1'b0; r.rd = 1'b1; r.data = refmem[vadr[11:0]];
         pend.push_back(r);
         exp_mem_en = 1'b1; exp_mem_we = 1'b0; exp_mem_adr = vadr;
         m_run = creq ? ((m_run + 1 > VMR) ? VMR : m_run + 1) : 0;
      end else begin
         exp_mem_en = 1'b0; exp_mem_we = 1'b0;
         if (!creq) m_run = 0;
      end
      cg = eg_cpu;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 16'h0, 32'h0, 0, 16'h0, dummy);
   endtask

   initial begin
      bit          cr, cwe, cg;
      logic [15:0] cadr;
      logic [31:0] cwd;

      reset    = 1'b1;
      ram_load = 1'b1;
      drive_idle();
      for (int i = 0; i < 4096; i++) refmem[i] = init_val(i);
      @(posedge clk);
      #1;
      ram_load = 1'b0;
      do_reset(2);

      // CPU-only read of the preloaded word.
      step(1, 0, 16'h0010, 32'h0, 0, 16'h0, dummy);
      idle(3);

      // CPU write, then read back; read is held until the slot after done.
      step(1, 1, 16'h0020, 32'h1234_5678, 0, 16'h0, dummy);
      for (int k = 0; k < 3; k++) step(1, 0, 16'h0020, 32'h0, 0, 16'h0, dummy);
      idle(3);

      // Back-to-back video stream.
      for (int k = 0; k < 8; k++) step(0, 0, 16'h0, 32'h0, 1, 16'(16'h0100 + k), dummy);
      idle(3);

      // Reset the cycle after a CPU read grant; then a fresh read completes.
      step(1, 0, 16'h0030, 32'h0, 0, 16'h0, dummy);
      do_reset(2);
      step(1, 0, 16'h0030, 32'h0, 0, 16'h0, dummy);
      idle(3);

      // Starvation guard with continuous video traffic.
      do_reset(1);
      for (int k = 0; k < 8; k++) begin
`ifdef VRAM_ARB_STATS_EN
         if (k == 5) begin
            check_val("stat_cpu_wait", stat_cpu_wait, 4);
            check_val("stat_vid_reads", stat_vid_reads, 4);
         end
`endif
         step(k < 5, 0, 16'h0040, 32'h0, 1, 16'(16'h0200 + k), cg);
         if (k == 4) check_val("guard_cpu_gnt_c4", cg, 1);
      end
      idle(3);

      // Randomized traffic over a small overlapping address window.
      cr = 1'b0; cwe = 1'b0; cadr = 16'h0; cwd = 32'h0;
      for (int k = 0; k < 1500; k++) begin
         if (!cr && $urandom_range(0, 2) == 0) begin
            cr   = 1'b1;
            cwe  = 1'($urandom_range(0, 1));
            cadr = 16'($urandom_range(0, 63));
            cwd  = $urandom;
         end
         step(cr, cwe, cadr, cwd, $urandom_range(0, 3) != 0,
              16'($urandom_range(0, 63)), cg);
         if (cg) cr = 1'b0;
      end
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vram_cpu_arbiter.md
Name: vram_cpu_arbiter

Overview:
- Shares one single-port synchronous memory (character/attribute RAM) between the multicycle MIPS core and the video character-map fetch unit.
- One access is issued per cycle at most.
- Video has priority for raster timing, with a bounded-run guard so the CPU cannot starve.
- Sits between the core's adr/writedata/memwrite/readdata port, the video fetcher, and the RAM macro. The core is held via a stall/handshake on the CPU side.

Parameters:
- AW, 16, memory word-address width.
- DW, 32, data width.
- VID_MAX_RUN, 4, maximum consecutive video grants while cpu_req is pending; must be ≥1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request; held stable until cpu_gnt
- cpu_we  in  1  1=write, 0=read
- cpu_adr  in  AW  CPU word address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  combinational; request accepted this cycle
- cpu_done  out  1  one-cycle pulse; read data valid / write complete
- cpu_rdata  out  DW  read data, valid with cpu_done
- vid_req  in  1  video read request
- vid_adr  in  AW  video word address
- vid_gnt  out  1  combinational; request accepted this cycle
- vid_rvalid  out  1  one-cycle pulse, read data valid
- vid_rdata  out  DW  video read data
- mem_en  out  1  RAM access enable (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_adr  out  AW  RAM address (registered)
- mem_wdata  out  DW  RAM write data (registered)
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_en

Behaviour:
- Reset is asynchronous and active-high, on clock clk. Reset values:
  - mem_en=0, mem_we=0, mem_adr=0, mem_wdata=0
  - cpu_done=0, vid_rvalid=0, cpu_rdata=0, vid_rdata=0
  - run counter=0, cpu_outstanding=0
- Grant decision is combinational in cycle N, evaluated in this order:
  1. cpu_eligible = cpu_req & !cpu_outstanding.
  2. If cpu_eligible and run_cnt==VID_MAX_RUN, then CPU wins.
  3. Else if vid_req, then video wins.
  4. Else if cpu_eligible, then CPU wins.
  5. Else no grant.
- At most one of cpu_gnt/vid_gnt is high in any cycle.
- Issue: the winner's adr/we/wdata are registered onto mem_* at edge N→N+1. mem_en=1 in N+1. Video accesses always have mem_we=0.
- Response: the RAM returns data in N+2. The source tag travels in a 2-stage pipeline alongside the access.
  - CPU winner: cpu_done pulses in N+2. For reads, cpu_rdata=mem_rdata. For writes, cpu_rdata holds its previous value.
  - Video winner: vid_rvalid pulses in N+2 with vid_rdata.
  - cpu_rdata and vid_rdata are registered and hold their value until the next respective response.
- Fixed CPU read latency: gnt to done is 2 cycles.
- cpu_outstanding is set at cpu_gnt and cleared in the cycle cpu_done is asserted. A new CPU grant is possible in the cycle after cpu_done (one CPU access in flight).
- Video is fully pipelined: back-to-back grants every cycle, responses in grant order.
- run_cnt behaviour:
  - Increments on each vid_gnt while cpu_req=1.
  - Clears on cpu_gnt, or in any cycle with cpu_req=0.
  - Saturates at VID_MAX_RUN.
- Worst-case CPU wait is VID_MAX_RUN cycles plus any outstanding-access drain.
- Idle cycle (no grant): mem_en=0; mem_adr/mem_wdata hold their values.
- Reset mid-operation: the in-flight tag pipeline is cleared, no cpu_done/vid_rvalid is produced for accesses issued before reset, and the RAM write in flight may or may not complete.
- Simultaneous cpu_req and vid_req at run_cnt<VID_MAX_RUN: video wins; cpu_req stays pending.
- No bypass: a CPU write followed by a video read of the same address in the next grant slot returns the new data, because RAM is accessed in issue order.

Optional Feature:
- Macro VRAM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_cpu_wait (32 bits) and stat_vid_reads (32 bits).
  - stat_cpu_wait counts cycles with cpu_eligible=1 and cpu_gnt=0.
  - stat_vid_reads counts vid_gnt.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package vram_arb_pkg:
  - Enum arb_src_t {SRC_NONE, SRC_CPU, SRC_VID}.
  - Default AW/DW/VID_MAX_RUN localparams.
- Sub-module arb_resp_pipe: 2-stage arb_src_t + write-flag pipeline that generates cpu_done/vid_rvalid and captures rdata.
- The arbiter FSM/counter stays in the top module.

Test Plan:
- CPU-only read: cpu_req=1, cpu_we=0, cpu_adr=0x0010 with RAM[0x10]=0xDEADBEEF → cpu_gnt in cycle 0, mem_en/mem_adr=0x0010 in cycle 1, cpu_done=1 and cpu_rdata=0xDEADBEEF in cycle 2.
- CPU write then read: write 0x12345678 to 0x0020, then read 0x0020 → write done at +2, second grant in the cycle after done, read returns 0x12345678.
- Video stream: vid_req=1 for 8 cycles, addresses 0x100..0x107 → vid_gnt every cycle, vid_rvalid 8 consecutive cycles starting 2 after the first grant, data in order.
- Starvation guard: vid_req continuous plus cpu_req from cycle 0, VID_MAX_RUN=4 → vid_gnt cycles 0-3, cpu_gnt cycle 4, video resumes cycle 5.
- Reset mid-flight: assert reset the cycle after a CPU read grant → no cpu_done, all outputs 0; after release, a new request completes normally.
- With VRAM_ARB_STATS_EN: the guard scenario above → stat_cpu_wait=4, stat_vid_reads=4 at cycle 5.
